// File: rtl/counterm_updown.sv
// Modulo-M up/down counter with parallel load, wrap/saturate mode,
// combinational terminal count for cascading and a registered wrap pulse.
module counterm_updown #(
  parameter int unsigned N = 5,
  parameter int unsigned M = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         up,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         sat,
  output logic [N-1:0] out,
  output logic         tc,
  output logic         wrap
);

  if (M < 2 || longint'(M) > (longint'(1) << N)) begin : g_bad_modulus
    $error("counterm_updown: modulus M=%0d out of range for N=%0d", M, N);
  end

  localparam logic [N-1:0] MaxVal = N'(M - 1);
  localparam logic [N-1:0] One    = N'(1);

  logic [N-1:0] count_q, count_d;
  logic         wrap_q, wrap_d;

  // Bounds are compared explicitly so M == 2**N never relies on natural overflow.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = (load_val > MaxVal) ? MaxVal : load_val;
    end else if (enable) begin
      if (up) begin
        if (count_q == MaxVal) begin
          if (!sat) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q + One;
        end
      end else begin
        if (count_q == '0) begin
          if (!sat) begin
            count_d = MaxVal;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q - One;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign out  = count_q;
  assign wrap = wrap_q;
  assign tc   = enable & ~load & (up ? (count_q == MaxVal) : (count_q == '0));

endmodule

// File: tb/tb_counterm_updown.sv
// Scoreboard bench for counterm_updown: stimulus pushes expectations, a negedge
// monitor pops and compares; extra instances cover M == 2**N and cascading.
module tb_counterm_updown;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable, up, load, sat;
  logic [4:0] load_val;
  logic [4:0] out;
  logic       tc, wrap;

  logic       en4;
  logic [3:0] out4;
  logic       tc4, wrap4;

  logic       cen;
  logic [4:0] lo_out, hi_out;
  logic       lo_tc, lo_wrap, hi_tc, hi_wrap;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0] out;
    logic       wrap;
    logic       tc;
    int         tag;
  } item_t;

  item_t sb[$];

  always #5 clk = ~clk;

  counterm_updown #(.N(5), .M(20)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
    .load_val(load_val), .sat(sat), .out(out), .tc(tc), .wrap(wrap)
  );

  counterm_updown #(.N(4), .M(16)) u_pow2 (
    .clk(clk), .reset(reset), .enable(en4), .up(1'b1), .load(1'b0),
    .load_val(4'd0), .sat(1'b0), .out(out4), .tc(tc4), .wrap(wrap4)
  );

  counterm_updown #(.N(5), .M(20)) u_lo (
    .clk(clk), .reset(reset), .enable(cen), .up(1'b1), .load(1'b0),
    .load_val(5'd0), .sat(1'b0), .out(lo_out), .tc(lo_tc), .wrap(lo_wrap)
  );

  counterm_updown #(.N(5), .M(20)) u_hi (
    .clk(clk), .reset(reset), .enable(lo_tc), .up(1'b1), .load(1'b0),
    .load_val(5'd0), .sat(1'b0), .out(hi_out), .tc(hi_tc), .wrap(hi_wrap)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expectation = state seen before this cycle's edge; tc uses the inputs driven here.
  task automatic step(input logic e, input logic u, input logic l, input logic s,
                      input logic [4:0] lv, input logic [4:0] eo, input logic ew,
                      input logic et, input int tag);
    @(posedge clk);
    #2;
    enable = e; up = u; load = l; sat = s; load_val = lv;
    sb.push_back('{out: eo, wrap: ew, tc: et, tag: tag});
  endtask

  task automatic drain();
    for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    drain();
    @(negedge clk);
    #1;
    reset = 1'b0; enable = 1'b0; load = 1'b0; up = 1'b1; sat = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      item_t it;
      it = sb.pop_front();
      checks++;
      if (out !== it.out || wrap !== it.wrap || tc !== it.tc) begin
        errors++;
        $display("FAIL vec%0d: out=%0d wrap=%0b tc=%0b expected out=%0d wrap=%0b tc=%0b",
                 it.tag, out, wrap, tc, it.out, it.wrap, it.tc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    reset = 1'b0; enable = 1'b0; up = 1'b1; load = 1'b0; sat = 1'b0; load_val = '0;
    en4 = 1'b0; cen = 1'b0;
    #3;
    check("reset_out", int'(out), 0);
    check("reset_wrap", int'(wrap), 0);
    @(negedge clk);
    #1;
    reset = 1'b1;

    // Up count 0..19 then wrap to 0.
    for (int i = 0; i <= 20; i++) begin
      v = i % 20;
      step(1, 1, 0, 0, 5'd0, 5'(v), i == 20, v == 19, 100 + i);
    end

    // Down count from reset: 0,19,18,...,0,19.
    do_reset();
    for (int i = 0; i <= 21; i++) begin
      v = (20 - (i % 20)) % 20;
      step(1, 0, 0, 0, 5'd0, 5'(v), (i % 20) == 1, v == 0, 200 + i);
    end

    // Saturate mode: up from 17, then down from 2.
    do_reset();
    step(0, 1, 1, 1, 5'd17, 5'd0,  0, 0, 300);
    step(1, 1, 0, 1, 5'd0,  5'd17, 0, 0, 301);
    step(1, 1, 0, 1, 5'd0,  5'd18, 0, 0, 302);
    step(1, 1, 0, 1, 5'd0,  5'd19, 0, 1, 303);
    step(1, 1, 0, 1, 5'd0,  5'd19, 0, 1, 304);
    step(1, 1, 0, 1, 5'd0,  5'd19, 0, 1, 305);
    step(0, 0, 1, 1, 5'd2,  5'd19, 0, 0, 306);
    step(1, 0, 0, 1, 5'd0,  5'd2,  0, 0, 307);
    step(1, 0, 0, 1, 5'd0,  5'd1,  0, 0, 308);
    step(1, 0, 0, 1, 5'd0,  5'd0,  0, 1, 309);
    step(1, 0, 0, 1, 5'd0,  5'd0,  0, 1, 310);
    step(0, 0, 0, 1, 5'd0,  5'd0,  0, 0, 311);

    // Load clamps and beats enable; a wrap-pending state is overridden by load.
    step(1, 1, 1, 0, 5'd25, 5'd0,  0, 0, 400);
    step(1, 1, 1, 0, 5'd7,  5'd19, 0, 0, 401);
    step(0, 1, 0, 0, 5'd0,  5'd7,  0, 0, 402);
    step(0, 1, 0, 0, 5'd0,  5'd7,  0, 0, 403);
    step(1, 0, 1, 0, 5'd19, 5'd7,  0, 0, 404);
    step(1, 1, 0, 0, 5'd0,  5'd19, 0, 1, 405);
    step(0, 1, 0, 0, 5'd0,  5'd0,  1, 0, 406);
    step(0, 1, 0, 0, 5'd0,  5'd0,  0, 0, 407);

    // Asynchronous reset between edges at out == 12.
    do_reset();
    for (int i = 0; i <= 12; i++) step(1, 1, 0, 0, 5'd0, 5'(i), 0, 0, 500 + i);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_out", int'(out), 0);
    check("async_wrap", int'(wrap), 0);
    @(negedge clk);
    check("held_in_reset", int'(out), 0);
    #1;
    reset = 1'b1;
    for (int i = 1; i <= 3; i++) step(1, 1, 0, 0, 5'd0, 5'(i), 0, 0, 600 + i);
    drain();
    enable = 1'b0;

    // M == 2**N instance wraps 15 -> 0.
    @(posedge clk);
    #2;
    en4 = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      check("pow2_out", int'(out4), i % 16);
      check("pow2_wrap", int'(wrap4), int'(i == 16));
    end
    en4 = 1'b0;

    // Cascade: combined value counts 0..399 then back to 0.
    @(posedge clk);
    #2;
    cen = 1'b1;
    for (int i = 0; i <= 400; i++) begin
      @(negedge clk);
      check("cascade_val", int'(hi_out) * 20 + int'(lo_out), i % 400);
      if (i == 399) check("cascade_hi_tc", int'(hi_tc), 1);
      if (i == 380) check("cascade_hi_tc_low", int'(hi_tc), 0);
      if (i == 400) check("cascade_hi_wrap", int'(hi_wrap), 1);
    end
    cen = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
